// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-high segment
// patterns ({g,f,e,d,c,b,a}), scan state encoding and digit-index width.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam int DIG_W = 2;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/module_seg7_scan_if.sv
// Data/display bundle of the scan driver: BCD value strobe in, multiplexed
// anode/segment lines and the sticky error flag out.
interface module_seg7_scan_if;

  logic [11:0] bcd_i;
  logic        bcd_valid_i;
  logic        blank_lz_i;
  logic [2:0]  an_o;
  logic [6:0]  seg_o;
  logic        err_o;

  modport master (
    output bcd_i, bcd_valid_i, blank_lz_i,
    input  an_o, seg_o, err_o
  );

  modport slave (
    input  bcd_i, bcd_valid_i, blank_lz_i,
    output an_o, seg_o, err_o
  );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational nibble to active-high segment pattern; A-F give a dash and
// raise o_invalid.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg,
  output logic       o_invalid
);

  always_comb begin
    o_seg     = SEG_DASH;
    o_invalid = 1'b0;
    case (i_nibble)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: begin
        o_seg     = SEG_DASH;
        o_invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/module_seg7_scan.sv
// 3-digit multiplexed seven-segment driver with blank interval and frame-aligned
// commit; outputs registered one cycle after state/counter/disp.
module module_seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES   = 27000,
  parameter int unsigned BLANK_CYCLES   = 270,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  module_seg7_scan_if.slave  bus
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  // Off levels double as XOR masks for the polarity inversion.
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_OFF  = AN_ACTIVE_LOW  ? 3'h7  : 3'h0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cyc_cnt;
  logic [DIG_W-1:0] r_dig_idx;
  logic [11:0]      r_snap;
  logic [11:0]      r_disp;
  logic             r_pend;
  logic [2:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_err;

  logic             w_slot_end;
  logic             w_blank_end;
  logic             w_boundary;
  logic [3:0]       w_nibble;
  logic [6:0]       w_dec_seg;
  logic             w_dec_invalid;
  logic             w_lz_blank;
  logic             w_drive;
  logic [2:0]       w_an_hi;
  logic [6:0]       w_seg_hi;

  assign w_slot_end  = (r_cyc_cnt == CW'(DIGIT_CYCLES - 1));
  assign w_blank_end = (r_cyc_cnt == CW'(BLANK_CYCLES - 1));
  assign w_boundary  = w_slot_end && (r_dig_idx == DIG_W'(2));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_BLANK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BLANK: if (w_blank_end) w_state_nxt = S_DRIVE;
      S_DRIVE: if (w_slot_end)  w_state_nxt = S_BLANK;
      default: w_state_nxt = S_BLANK;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cyc_cnt <= '0;
      r_dig_idx <= '0;
    end else if (w_slot_end) begin
      r_cyc_cnt <= '0;
      r_dig_idx <= (r_dig_idx == DIG_W'(2)) ? '0 : r_dig_idx + DIG_W'(1);
    end else begin
      r_cyc_cnt <= r_cyc_cnt + CW'(1);
    end
  end

  // A strobe landing on the boundary bypasses the snapshot straight into disp.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_snap <= '0;
      r_disp <= '0;
      r_pend <= 1'b0;
    end else if (w_boundary) begin
      r_pend <= 1'b0;
      if (bus.bcd_valid_i) begin
        r_snap <= bus.bcd_i;
        r_disp <= bus.bcd_i;
      end else if (r_pend) begin
        r_disp <= r_snap;
      end
    end else if (bus.bcd_valid_i) begin
      r_snap <= bus.bcd_i;
      r_pend <= 1'b1;
    end
  end

  always_comb begin
    case (r_dig_idx)
      DIG_W'(0): w_nibble = r_disp[3:0];
      DIG_W'(1): w_nibble = r_disp[7:4];
      default:   w_nibble = r_disp[11:8];
    endcase
  end

  seg7_decoder u_dec (
    .i_nibble  (w_nibble),
    .o_seg     (w_dec_seg),
    .o_invalid (w_dec_invalid)
  );

  assign w_lz_blank = bus.blank_lz_i &&
                      (((r_dig_idx == DIG_W'(2)) && (r_disp[11:8] == 4'd0)) ||
                       ((r_dig_idx == DIG_W'(1)) && (r_disp[11:4] == 8'd0)));
  assign w_drive    = (r_state == S_DRIVE) && !w_lz_blank;
  assign w_an_hi    = w_drive ? (3'b001 << r_dig_idx) : 3'b000;
  assign w_seg_hi   = w_drive ? w_dec_seg : 7'h00;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_err <= 1'b0;
    end else begin
      r_an  <= w_an_hi ^ AN_OFF;
      r_seg <= w_seg_hi ^ SEG_OFF;
      r_err <= r_err | (w_drive && w_dec_invalid);
    end
  end

  assign bus.an_o  = r_an;
  assign bus.seg_o = r_seg;
  assign bus.err_o = r_err;

endmodule

// File: tb/tb_module_seg7_scan.sv
// Directed bench for module_seg7_scan with DIGIT_CYCLES=8, BLANK_CYCLES=2, active-low outputs.
// cyc counts posedges since reset release; outputs are sampled on the following negedge.
module tb_module_seg7_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;

  module_seg7_scan_if bus ();

  module_seg7_scan #(
    .DIGIT_CYCLES   (8),
    .BLANK_CYCLES   (2),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) tick();
  endtask

  // Holds bcd_valid_i high across posedge number k.
  task automatic strobe_at(input int k, input logic [11:0] v);
    run_to(k - 1);
    bus.bcd_i       = v;
    bus.bcd_valid_i = 1'b1;
    tick();
    bus.bcd_valid_i = 1'b0;
  endtask

  task automatic chk_disp(input int k, input string tag, input logic [2:0] an, input logic [6:0] seg);
    run_to(k);
    chk($sformatf("%s_an@%0d", tag, k), {29'd0, bus.an_o}, {29'd0, an});
    chk($sformatf("%s_seg@%0d", tag, k), {25'd0, bus.seg_o}, {25'd0, seg});
  endtask

  task automatic chk_err(input int k, input string tag, input logic exp);
    run_to(k);
    chk($sformatf("%s_err@%0d", tag, k), {31'd0, bus.err_o}, {31'd0, exp});
  endtask

  initial begin
    bus.bcd_i       = 12'h000;
    bus.bcd_valid_i = 1'b0;
    bus.blank_lz_i  = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_an",  {29'd0, bus.an_o},  32'h7);
    chk("rst_seg", {25'd0, bus.seg_o}, 32'h7F);
    chk("rst_err", {31'd0, bus.err_o}, 32'h0);
    rst = 1'b1;
    cyc = 0;

    // Reset release: 2 blank cycles, 6 cycles of units "0", then tens-slot blank.
    for (int k = 1; k <= 10; k++) begin
      if (k <= 2 || k >= 9) chk_disp(k, "boot_blank", 3'b111, 7'h7F);
      else                  chk_disp(k, "boot_units0", 3'b110, 7'h40);
    end

    // Commit only on the frame boundary.
    strobe_at(13, 12'h123);
    chk_disp(19, "old_hund", 3'b011, 7'h40);
    chk_disp(27, "c123_units", 3'b110, 7'h30);
    chk_disp(33, "c123_tblank", 3'b111, 7'h7F);
    chk_disp(35, "c123_tens", 3'b101, 7'h24);
    chk_disp(43, "c123_hund", 3'b011, 7'h79);

    // Last write wins.
    strobe_at(50, 12'h456);
    chk_disp(51, "pend_units", 3'b110, 7'h30);
    strobe_at(60, 12'h789);
    chk_disp(75, "lww_units", 3'b110, 7'h10);
    chk_disp(83, "lww_tens", 3'b101, 7'h00);
    chk_disp(91, "lww_hund", 3'b011, 7'h78);

    // Strobe on the boundary cycle is shown in the very next frame.
    strobe_at(96, 12'h250);
    chk_disp(99, "byp_units", 3'b110, 7'h40);
    chk_disp(107, "byp_tens", 3'b101, 7'h12);

    // Leading-zero blanking on, then off.
    run_to(109);
    bus.blank_lz_i = 1'b1;
    strobe_at(110, 12'h007);
    chk_disp(115, "byp_hund_lz", 3'b011, 7'h24);
    chk_disp(123, "lz_units", 3'b110, 7'h78);
    chk_disp(131, "lz_tens", 3'b111, 7'h7F);
    chk_disp(139, "lz_hund", 3'b111, 7'h7F);
    run_to(140);
    bus.blank_lz_i = 1'b0;
    chk_disp(147, "nolz_units", 3'b110, 7'h78);
    chk_disp(155, "nolz_tens", 3'b101, 7'h40);
    chk_disp(163, "nolz_hund", 3'b011, 7'h40);
    chk_err(163, "pre_bad", 1'b0);

    // Invalid nibble in tens: dash and sticky error from the first tens drive cycle.
    strobe_at(166, 12'h0A5);
    chk_disp(171, "bad_units", 3'b110, 7'h12);
    chk_err(171, "bad_units", 1'b0);
    chk_err(178, "bad_tblank", 1'b0);
    chk_disp(179, "bad_tens", 3'b101, 7'h3F);
    chk_err(179, "bad_tens", 1'b1);
    chk_disp(187, "bad_hund", 3'b011, 7'h40);
    chk_err(195, "bad_sticky", 1'b1);

    // Async reset during hundreds drive with a pending snapshot.
    strobe_at(198, 12'h999);
    chk_disp(211, "pre_arst_hund", 3'b011, 7'h40);
    #2 rst = 1'b0;
    #1;
    chk("arst_an",  {29'd0, bus.an_o},  32'h7);
    chk("arst_seg", {25'd0, bus.seg_o}, 32'h7F);
    chk("arst_err", {31'd0, bus.err_o}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    chk_disp(1, "post_blank", 3'b111, 7'h7F);
    chk_disp(3, "post_units", 3'b110, 7'h40);
    chk_disp(11, "post_tens", 3'b101, 7'h40);
    chk_disp(19, "post_hund", 3'b011, 7'h40);
    chk_disp(27, "post_f1_units", 3'b110, 7'h40);
    chk_disp(35, "post_f1_tens", 3'b101, 7'h40);
    chk_err(35, "post_err", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/module_seg7_scan.md
# module_seg7_scan

Time-multiplexed 3-digit seven-segment display driver for the basic-counter design. It sits directly downstream of the binary-to-BCD converter and consumes its 12-bit packed BCD result (hundreds, tens, units). It snapshots each new value and commits it to the display only on a frame boundary, so a frame never shows a mix of old and new digits. It scans the digits with an anti-ghosting blank interval, suppresses leading zeros on request, and flags non-BCD nibbles.

## Interface
Parameters:
- DIGIT_CYCLES, 27000: clock cycles per digit slot, including the blank interval.
- BLANK_CYCLES, 270: cycles at the start of each slot with all anodes off. Legal range is 1 ≤ BLANK_CYCLES < DIGIT_CYCLES.
- SEG_ACTIVE_LOW, 1: when 1, seg_o is inverted at the output register.
- AN_ACTIVE_LOW, 1: when 1, an_o is inverted at the output register.

Ports:
- clk_i, in, 1: the single clock.
- rst_i, in, 1: reset, asynchronous, active-low.
- bcd_i, in, 12: packed BCD. Bits [11:8] are hundreds, [7:4] tens, [3:0] units.
- bcd_valid_i, in, 1: one-cycle strobe; bcd_i is valid while it is high.
- blank_lz_i, in, 1: enables leading-zero blanking. Sampled every cycle.
- an_o, out, 3: digit enables. an_o[0] drives units, an_o[2] drives hundreds.
- seg_o, out, 7: segment lines in the order {g,f,e,d,c,b,a}.
- err_o, out, 1: sticky flag, set when a committed digit is not valid BCD.

## Operation
Registers:
- snap_r: latest accepted value.
- pend_r: a snapshot is waiting to be committed.
- disp_r: the committed value being displayed.
- cyc_cnt: counts 0..DIGIT_CYCLES-1 within a slot.
- dig_idx: current digit, 0..2.
- state: S_BLANK or S_DRIVE.

Input capture:
- bcd_valid_i=1 loads snap_r ← bcd_i and sets pend_r.
- Back-to-back strobes overwrite snap_r; only the last value before the boundary is committed.

State machine, per slot:
- S_BLANK lasts while cyc_cnt < BLANK_CYCLES. All anodes are off.
- When cyc_cnt == BLANK_CYCLES-1, go to S_DRIVE.
- When cyc_cnt == DIGIT_CYCLES-1, go to S_BLANK, reset cyc_cnt to 0, and advance dig_idx as 0→1→2→0.

Frame boundary and commit:
- The frame boundary is the last cycle of the dig_idx=2 slot.
- At the boundary, if pend_r=1: disp_r ← snap_r and pend_r clears.
- If bcd_valid_i is high on the boundary cycle, bcd_i goes directly into disp_r (and into snap_r), and pend_r ends at 0.

Decoding (active-high patterns, before polarity inversion):
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Nibbles A–F display 40 (a dash) and set err_o.
- err_o is checked only when the nibble is driven in S_DRIVE.

Leading-zero blanking, when blank_lz_i=1:
- Hundreds blank (seg 00, anode off) if the hundreds digit is 0.
- Tens blank if both hundreds and tens are 0.
- Units are never blanked, so 000 displays as "0".

Outputs:
- an_o is one-hot in S_DRIVE on the dig_idx bit. It is all-off in S_BLANK and for blanked digits.
- seg_o is 00 whenever its anode is off.

## Timing
- All outputs are registered and appear one cycle after the state, counter or disp_r value that produces them.
- Reset values:
  - an_o all off (3'b111 when AN_ACTIVE_LOW).
  - seg_o all off (7'h7F when SEG_ACTIVE_LOW).
  - err_o=0.
  - snap_r, disp_r and pend_r are 0.
  - state=S_BLANK, dig_idx=0, cyc_cnt=0.
- Reset mid-operation: all outputs go to their reset values asynchronously, and any pending snapshot is discarded.
- The first driven digit after reset is units, showing "0", on cycle BLANK_CYCLES+1.
- Frame length is 3·DIGIT_CYCLES.
- Commit latency from a strobe to disp_r is at most 3·DIGIT_CYCLES cycles.
- Commit latency to the units digit being visible is at most 3·DIGIT_CYCLES + BLANK_CYCLES + 1 cycles.
- Counters wrap exactly; no slot is ever lengthened or shortened.

## Structure
- Shared package seg7_pkg holds:
  - the ten segment-pattern constants and the dash pattern;
  - the state encoding S_BLANK / S_DRIVE;
  - the digit-index width.
- Sub-module seg7_decoder is combinational: 4-bit nibble in, 7-bit active-high pattern and an invalid flag out. It is instantiated once, on the nibble muxed by dig_idx.

## Test plan
All scenarios use DIGIT_CYCLES=8, BLANK_CYCLES=2, SEG_ACTIVE_LOW=1 and AN_ACTIVE_LOW=1.

- **Reset:** release rst_i → an_o=111 and seg_o=7F for 2 cycles, then an_o=110 with seg_o=40 ("0") for 6 cycles.
- **Commit on boundary:** strobe 0x123 mid-frame → the current frame still shows the old value. The next frame shows units 0x30 ("3") on an_o=110, tens 0x24 ("2") on 101, and hundreds 0x79 ("1") on 011.
- **Last-write-wins and boundary bypass:**
  - Strobe 0x456, then 0x789 before the boundary → only 789 is displayed.
  - A strobe on the boundary cycle is displayed in the very next frame.
- **Leading-zero blanking:** value 0x007 with blank_lz_i=1 → the tens and hundreds slots have an_o=111 and seg_o=7F; units show "7" (0x78). With blank_lz_i=0, the display shows "007".
- **Invalid BCD:** strobe 0x0A5 → the tens digit shows a dash (seg_o=3F). err_o rises in the first tens S_DRIVE cycle and stays 1 until reset.
- **Asynchronous reset mid-scan:** assert rst_i in S_DRIVE of the hundreds slot with pend_r=1 → outputs go to reset values immediately (without a clock edge). After release, the display shows "0" and the pending value is never shown.
